// File: rtl/console_uart_tx.sv
// Console UART transmitter: bus-mapped TX data and STATUS registers, a byte FIFO and an 8N1 serializer.
// Defining CONSOLE_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit (8E1).
`timescale 1ns/1ps

`ifndef READ
`define READ 1'b0
`endif
`ifndef WRITE
`define WRITE 1'b1
`endif

module console_uart_tx #(
   parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
   parameter int          CLK_DIVISOR  = 16,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_memory_interface_enable,
   input  logic        data_memory_interface_state,
   input  logic [31:0] data_memory_interface_address,
   input  logic [3:0]  data_memory_interface_frame_mask,
   inout  wire  [31:0] data_memory_interface_data,
   output logic        tx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

`ifdef CONSOLE_TX_PARITY_EN
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
`else
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
`endif

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic [2:0]    fsm_state;
   logic [15:0]   baud_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift_reg;
`ifdef CONSOLE_TX_PARITY_EN
   logic          parity_bit;
`endif

   logic          push_req;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic          busy;
   logic          baud_done;
   logic          status_sel;
   logic [7:0]    head_byte;
   logic [3:0]    count_sat;
   logic [31:0]   status_word;
   logic          unused_bus_bits;

   assign push_req   = data_memory_interface_enable
                    && (data_memory_interface_state == `WRITE)
                    && (data_memory_interface_address == BASE_ADDRESS)
                    && data_memory_interface_frame_mask[3];
   assign status_sel = reset && data_memory_interface_enable
                    && (data_memory_interface_state == `READ)
                    && (data_memory_interface_address == BASE_ADDRESS + 32'd4);

   assign full      = (count == CW'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign busy      = (fsm_state != IDLE);
   assign baud_done = (baud_cnt == 16'(CLK_DIVISOR - 1));
   assign head_byte = fifo_mem[rd_ptr];
   assign push      = push_req && !full;
   // A byte leaves the FIFO either from IDLE or at the very end of STOP, so frames chain with no gap.
   assign pop       = !empty && ((fsm_state == IDLE) || ((fsm_state == STOP) && baud_done));

   assign count_sat   = (32'(count) > 32'd15) ? 4'd15 : 4'(count);
   assign status_word = {24'b0, count_sat, overflow, empty, full, busy};
   assign data_memory_interface_data = status_sel ? status_word : 32'bz;

   assign unused_bus_bits = ^{data_memory_interface_frame_mask[2:0], data_memory_interface_data[31:8]};

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= data_memory_interface_data[7:0];
      end
   end

   // Pointers wrap naturally because the depth is a power of two; a push into a full FIFO is dropped even if a pop frees a slot on the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Overflow is sticky until a STATUS read completes; a fresh overflow on that same edge wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (push_req && full) begin
         overflow <= 1'b1;
      end else if (status_sel) begin
         overflow <= 1'b0;
      end
   end

   // tx is registered and loaded with the level of the state being entered, so the line changes exactly on bit boundaries.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fsm_state  <= IDLE;
         baud_cnt   <= '0;
         bit_cnt    <= '0;
         shift_reg  <= '0;
         tx         <= 1'b1;
`ifdef CONSOLE_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (fsm_state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               tx       <= 1'b1;
               if (pop) begin
                  shift_reg  <= head_byte;
`ifdef CONSOLE_TX_PARITY_EN
                  parity_bit <= ^head_byte;
`endif
                  fsm_state  <= START;
                  tx         <= 1'b0;
               end
            end
            START: begin
               if (baud_done) begin
                  baud_cnt  <= '0;
                  bit_cnt   <= '0;
                  fsm_state <= DATA;
                  tx        <= shift_reg[0];
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt   <= '0;
`ifdef CONSOLE_TX_PARITY_EN
                     fsm_state <= PARITY;
                     tx        <= parity_bit;
`else
                     fsm_state <= STOP;
                     tx        <= 1'b1;
`endif
                  end else begin
                     bit_cnt   <= bit_cnt + 3'd1;
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     tx        <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
`ifdef CONSOLE_TX_PARITY_EN
            PARITY: begin
               if (baud_done) begin
                  baud_cnt  <= '0;
                  fsm_state <= STOP;
                  tx        <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
`endif
            STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  if (pop) begin
                     shift_reg  <= head_byte;
`ifdef CONSOLE_TX_PARITY_EN
                     parity_bit <= ^head_byte;
`endif
                     fsm_state  <= START;
                     tx         <= 1'b0;
                  end else begin
                     fsm_state <= IDLE;
                     tx        <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            default: begin
               fsm_state <= IDLE;
               baud_cnt  <= '0;
               bit_cnt   <= '0;
               tx        <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/console_uart_tx.md
CONSOLE_UART_TX -- requirements
Module: console_uart_tx

Interface
REQ-001 The parameter BASE_ADDRESS SHALL default to 32'h1000_0000 and set the console TX data register address; the STATUS register SHALL be at BASE_ADDRESS+4.
REQ-002 The parameter CLK_DIVISOR SHALL default to 16 and set the clock cycles per serial bit (legal range 2..65535).
REQ-003 The parameter FIFO_DEPTH SHALL default to 8 and set the byte FIFO depth (power of two, 2..64).
REQ-004 Port clk SHALL be a 1-bit input and the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset SHALL be a 1-bit input, asynchronous and active-low.
REQ-006 Port data_memory_interface_enable SHALL be a 1-bit input marking an active bus access.
REQ-007 Port data_memory_interface_state SHALL be a 1-bit input selecting `READ or `WRITE.
REQ-008 Port data_memory_interface_address SHALL be a 32-bit input carrying the byte address, decoded by full 32-bit compare.
REQ-009 Port data_memory_interface_frame_mask SHALL be a 4-bit input in which bit 3 enables byte lane [7:0].
REQ-010 Port data_memory_interface_data SHALL be a 32-bit inout carrying write data in and status out, high-Z when not driven.
REQ-011 Port tx SHALL be a 1-bit output carrying the serial line, idle high.

Function
REQ-012 A write to BASE_ADDRESS SHALL be accepted on a rising edge with enable=1, state=`WRITE and frame_mask[3]=1, pushing data[7:0] into the FIFO; frame_mask[3]=0 SHALL leave the FIFO unchanged.
REQ-013 A write while the FIFO is full SHALL be dropped and SHALL set sticky STATUS.overflow, even if a pop occurs in the same cycle.
REQ-014 While enable=1, state=`READ and address=BASE_ADDRESS+4, the block SHALL drive data combinationally with {24'b0, count[3:0], overflow, empty, full, busy}; count saturates at 15.
REQ-015 In all other cycles the block SHALL drive data to high-Z.
REQ-016 A STATUS read SHALL clear overflow on the rising edge ending the read, unless an overflowing write occurs on that same edge.
REQ-017 The transmitter FSM SHALL have states IDLE, START, DATA and STOP, plus PARITY when it is compiled in (REQ-026).
REQ-018 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte and enter START on the next edge; tx SHALL go low on the edge after the accepting write edge when the FIFO was empty.
REQ-019 Each state SHALL hold for exactly CLK_DIVISOR cycles per bit.
REQ-020 Frame order SHALL be: START (tx=0), 8 DATA bits LSB first, STOP (tx=1), then IDLE, or back-to-back START if the FIFO is non-empty; there SHALL be no idle gap between frames.
REQ-021 busy SHALL be 1 in every state other than IDLE.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full=(count==FIFO_DEPTH) and empty=(count==0).
REQ-023 A simultaneous push and pop on a non-full FIFO SHALL leave count unchanged.

Reset
REQ-024 reset=0 SHALL immediately and asynchronously force tx=1, FSM=IDLE, FIFO empty, overflow=0, bit and baud counters=0, and data bus high-Z.
REQ-025 Reset mid-frame SHALL abort the frame; the first frame after reset release SHALL start only on a new accepted write.

Configuration
REQ-026 With the macro CONSOLE_TX_PARITY_EN defined, the FSM SHALL insert a PARITY state between DATA and STOP that sends even parity (XOR of the 8 data bits) for CLK_DIVISOR cycles, giving an 11-bit frame.
REQ-027 Without CONSOLE_TX_PARITY_EN, no PARITY state or logic SHALL exist, giving a 10-bit 8N1 frame.

Verification
REQ-028 CLK_DIVISOR=4, write 0x41 to 32'h1000_0000 -> tx low 1 cycle later for 4 cycles, then bits 1,0,0,0,0,0,1,0, then high 4 cycles; 40 cycles total; busy high throughout.
REQ-029 9 back-to-back writes with FIFO_DEPTH=8 while the FSM is busy -> 9th byte dropped; STATUS read = full=1, overflow=1; an immediate second read shows overflow=0; exactly 9 frames if the first byte was already popped, otherwise 8 frames.
REQ-030 Write 0x55 then 0xAA -> two frames with no idle cycle between the STOP of frame 1 and the START of frame 2.
REQ-031 Assert reset at cycle 10 of a frame -> tx=1 in the same cycle, STATUS after release = empty=1, busy=0, count=0.
REQ-032 CONSOLE_TX_PARITY_EN defined, write 0x41 then 0x07 -> parity bits 0 and 1 respectively, each frame 44 cycles at CLK_DIVISOR=4.
REQ-033 Read 32'h1000_0000 or write with frame_mask=4'b0111 -> data bus stays high-Z and the FIFO is unchanged.
